// File: rtl/alu_share_ctrl.sv
// Time-shares one external combinational 4-function ALU between two requesters.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_share_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Req0,
    input  logic [N-1:0]     A0,
    input  logic [N-1:0]     B0,
    input  logic [1:0]       Fn0,
    input  logic             Req1,
    input  logic [N-1:0]     A1,
    input  logic [N-1:0]     B1,
    input  logic [1:0]       Fn1,
    output logic             Ack0,
    output logic             Ack1,
    output logic             Done0,
    output logic             Done1,
    output logic [2*N-1:0]   ResultOut,
    output logic             Busy,
    output logic [7:0]       OpCount,
    output logic [N-1:0]     AluA,
    output logic [N-1:0]     AluB,
    output logic [1:0]       AluFunction,
    input  logic [2*N-1:0]   AluResult
);

    localparam int unsigned RW = 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   grant;
    logic   pick1;

`ifdef ALU_SHARE_FIXED_PRIO_EN
    // Requester 0 always wins a tie.
    always_comb begin
        pick1 = Req1 & ~Req0;
    end
`else
    logic last;

    // On a tie, grant the requester that was not served last.
    always_comb begin
        pick1 = Req1 & (~Req0 | ~last);
    end
`endif

    assign Busy = (state != IDLE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            Ack0        <= 1'b0;
            Ack1        <= 1'b0;
            Done0       <= 1'b0;
            Done1       <= 1'b0;
            ResultOut   <= RW'(0);
            OpCount     <= 8'd0;
            AluA        <= N'(0);
            AluB        <= N'(0);
            AluFunction <= 2'b00;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last        <= 1'b1;
`endif
        end else begin
            Ack0  <= 1'b0;
            Ack1  <= 1'b0;
            Done0 <= 1'b0;
            Done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req0 | Req1) begin
                        grant       <= pick1;
                        AluA        <= pick1 ? A1 : A0;
                        AluB        <= pick1 ? B1 : B0;
                        AluFunction <= pick1 ? Fn1 : Fn0;
                        Ack0        <= ~pick1;
                        Ack1        <= pick1;
`ifndef ALU_SHARE_FIXED_PRIO_EN
                        last        <= pick1;
`endif
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU has settled on the registered operands by now.
                    ResultOut <= AluResult;
                    Done0     <= ~grant;
                    Done1     <= grant;
                    OpCount   <= OpCount + 8'd1;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl with an in-bench golden ALU and transaction model.
module tb_alu_share_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned RW = 2 * N;

    logic           clk = 1'b0;
    logic           Reset;
    logic           Req0, Req1;
    logic [N-1:0]   A0, B0, A1, B1;
    logic [1:0]     Fn0, Fn1;
    logic           Ack0, Ack1, Done0, Done1, Busy;
    logic [RW-1:0]  ResultOut;
    logic [7:0]     OpCount;
    logic [N-1:0]   AluA, AluB;
    logic [1:0]     AluFunction;
    logic [RW-1:0]  AluResult;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    bit             m_last;
    logic [7:0]     m_count;

    always #5 clk = ~clk;

    alu_share_ctrl #(.N(N)) dut (
        .Clock(clk), .Reset(Reset),
        .Req0(Req0), .A0(A0), .B0(B0), .Fn0(Fn0),
        .Req1(Req1), .A1(A1), .B1(B1), .Fn1(Fn1),
        .Ack0(Ack0), .Ack1(Ack1), .Done0(Done0), .Done1(Done1),
        .ResultOut(ResultOut), .Busy(Busy), .OpCount(OpCount),
        .AluA(AluA), .AluB(AluB), .AluFunction(AluFunction),
        .AluResult(AluResult)
    );

    function automatic logic [RW-1:0] golden(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [1:0] fn);
        case (fn)
            2'b00:   return RW'(a) + RW'(b);
            2'b01:   return RW'(|{a, b});
            2'b10:   return RW'(&{a, b});
            default: return {a, b};
        endcase
    endfunction

    assign AluResult = golden(AluA, AluB, AluFunction);

    function automatic bit model_pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
            return 1'b0;
`else
            return !m_last;
`endif
        end
        return r1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts at a negedge in an IDLE cycle; returns at the negedge of the next IDLE cycle.
    task automatic run_op(input bit r0, input bit r1,
                          input logic [N-1:0] a0, input logic [N-1:0] b0, input logic [1:0] f0,
                          input logic [N-1:0] a1, input logic [N-1:0] b1, input logic [1:0] f1,
                          input bit hold, input bit poke, output bit won);
        bit g;
        logic [N-1:0]  ea, eb;
        logic [1:0]    ef;
        logic [RW-1:0] er;
        g  = model_pick(r0, r1);
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        ef = g ? f1 : f0;
        er = golden(ea, eb, ef);
        Req0 = r0; Req1 = r1;
        A0 = a0; B0 = b0; Fn0 = f0;
        A1 = a1; B1 = b1; Fn1 = f1;
        @(negedge clk);
        m_last = g;
        won = Ack1;
        chk("ack0", 32'(Ack0), 32'(!g));
        chk("ack1", 32'(Ack1), 32'(g));
        chk("done_in_ack_cycle", 32'({Done0, Done1}), 32'(0));
        chk("busy_exec", 32'(Busy), 32'(1));
        chk("alu_a", 32'(AluA), 32'(ea));
        chk("alu_b", 32'(AluB), 32'(eb));
        chk("alu_fn", 32'(AluFunction), 32'(ef));
        if (!hold) begin
            Req0 = 1'b0; Req1 = 1'b0;
        end
        A0 = ~a0; B0 = ~b0; Fn0 = ~f0;
        A1 = ~a1; B1 = ~b1; Fn1 = ~f1;
        if (poke && !hold) begin
            Req0 = 1'b1; Req1 = 1'b1;
        end
        @(negedge clk);
        m_count = m_count + 8'd1;
        chk("done0", 32'(Done0), 32'(!g));
        chk("done1", 32'(Done1), 32'(g));
        chk("ack_in_done_cycle", 32'({Ack0, Ack1}), 32'(0));
        chk("result", 32'(ResultOut), 32'(er));
        chk("opcount", 32'(OpCount), 32'(m_count));
        chk("busy_done", 32'(Busy), 32'(1));
        if (poke && !hold) begin
            Req0 = 1'b0; Req1 = 1'b0;
        end
        @(negedge clk);
        chk("busy_idle", 32'(Busy), 32'(0));
        chk("ack_idle", 32'({Ack0, Ack1}), 32'(0));
        chk("done_idle", 32'({Done0, Done1}), 32'(0));
        chk("result_hold", 32'(ResultOut), 32'(er));
        chk("alu_a_hold", 32'(AluA), 32'(ea));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_acks"}, 32'({Ack0, Ack1}), 32'(0));
        chk({tag, "_dones"}, 32'({Done0, Done1}), 32'(0));
        chk({tag, "_busy"}, 32'(Busy), 32'(0));
        chk({tag, "_result"}, 32'(ResultOut), 32'(0));
        chk({tag, "_opcount"}, 32'(OpCount), 32'(0));
        chk({tag, "_alu"}, 32'({AluA, AluB, AluFunction}), 32'(0));
    endtask

    typedef struct {
        bit            r0;
        bit            r1;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [1:0]    fn;
        logic [RW-1:0] exp;
    } vec_t;

    vec_t tbl[8];
    bit   exp_rr[8];

    initial begin
        bit won;
        int ops;
        bit r0, r1;

        tbl[0] = '{1'b1, 1'b0, 4'h3, 4'h5, 2'b00, 8'h08};
        tbl[1] = '{1'b0, 1'b1, 4'hA, 4'h5, 2'b11, 8'hA5};
        tbl[2] = '{1'b0, 1'b1, 4'hF, 4'hF, 2'b10, 8'h01};
        tbl[3] = '{1'b0, 1'b1, 4'h0, 4'h0, 2'b01, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 4'h1, 4'h0, 2'b00, 8'h01};
        tbl[5] = '{1'b1, 1'b0, 4'hF, 4'hF, 2'b00, 8'h1E};
        tbl[6] = '{1'b0, 1'b1, 4'h8, 4'h0, 2'b01, 8'h01};
        tbl[7] = '{1'b1, 1'b0, 4'hE, 4'hF, 2'b10, 8'h00};
`ifdef ALU_SHARE_FIXED_PRIO_EN
        exp_rr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_rr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif

        Reset = 1'b1;
        Req0 = 1'b0; Req1 = 1'b0;
        A0 = '0; B0 = '0; Fn0 = '0; A1 = '0; B1 = '0; Fn1 = '0;
        m_last = 1'b1;
        m_count = 8'd0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        Reset = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Directed single-requester vectors
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].r0, tbl[i].r1, tbl[i].a, tbl[i].b, tbl[i].fn,
                   tbl[i].a, tbl[i].b, tbl[i].fn, 1'b0, 1'b0, won);
            chk("tbl_result", 32'(ResultOut), 32'(tbl[i].exp));
        end

        // Reset during EXEC drops the transaction and the pointer
        Req0 = 1'b1; Req1 = 1'b0;
        A0 = 4'h3; B0 = 4'h5; Fn0 = 2'b00;
        @(negedge clk);
        chk("midreset_ack0", 32'(Ack0), 32'(1));
        Req0 = 1'b0;
        #2 Reset = 1'b1;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        Reset = 1'b0;
        m_last = 1'b1;
        m_count = 8'd0;
        @(negedge clk);
        chk("midreset_no_done", 32'({Done0, Done1}), 32'(0));
        chk("midreset_opcount", 32'(OpCount), 32'(0));

        // Tie handling: dropped after Ack and re-raised, then held continuously
        for (int k = 0; k < 8; k++) begin
            run_op(1'b1, 1'b1, 4'(k), 4'(k + 3), 2'(k), 4'(~k), 4'(k + 7), 2'(k + 1),
                   k >= 4, 1'b0, won);
            chk("rr_order", 32'(won), 32'(exp_rr[k]));
        end
        Req0 = 1'b0; Req1 = 1'b0;
        @(negedge clk);
        chk("idle_gap_busy", 32'(Busy), 32'(0));
        chk("idle_gap_ack", 32'({Ack0, Ack1}), 32'(0));

        // Randomized traffic, long enough to wrap OpCount
        ops = 0;
        while (ops < 270) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) begin
                Req0 = 1'b0; Req1 = 1'b0;
                @(negedge clk);
                chk("rand_idle_busy", 32'(Busy), 32'(0));
                chk("rand_idle_ack", 32'({Ack0, Ack1}), 32'(0));
            end else begin
                run_op(r0, r1, 4'($urandom), 4'($urandom), 2'($urandom),
                       4'($urandom), 4'($urandom), 2'($urandom),
                       $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, won);
                ops++;
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        @(negedge clk);
        chk("final_opcount", 32'(OpCount), 32'(m_count));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
